// File: rtl/button_debouncer_pkg.sv
// Shared state encoding and default sizing for the push-button debouncer.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int CNT_WIDTH_DEFAULT       = 8;

endpackage

// File: rtl/button_debouncer_if.sv
// Raw button in, debounced level and edge strobes out.
interface button_debouncer_if;

    logic input_push_button3_raw_3;
    logic output_led1_d_4;
    logic output_led2_rise_5;
    logic output_led3_fall_6;

    modport master (
        output input_push_button3_raw_3,
        input  output_led1_d_4,
        input  output_led2_rise_5,
        input  output_led3_fall_6
    );

    modport slave (
        input  input_push_button3_raw_3,
        output output_led1_d_4,
        output output_led2_rise_5,
        output output_led3_fall_6
    );

endinterface

// File: rtl/button_sync.sv
// Two-flop synchronizer with asynchronous active-low clear.
module button_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic sync
);

    logic sync1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync  <= sync1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Synchronizes a bouncing button and accepts a new level only after
// DEBOUNCE_CYCLES consecutive identical synchronized samples.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
    input  logic               input_clock1_clk_1,
    input  logic               input_input_switch2__clear_2,
    button_debouncer_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
        (2 ** CNT_WIDTH) <= DEBOUNCE_CYCLES) begin : g_bad_param
        $error("button_debouncer: illegal DEBOUNCE_CYCLES/CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;
    state_t               state;
    logic                 level;
    logic                 rise;
    logic                 fall;

    button_sync u_sync (
        .clk   (input_clock1_clk_1),
        .rst_n (input_input_switch2__clear_2),
        .raw   (bus.input_push_button3_raw_3),
        .sync  (sync2)
    );

    // Entering a WAIT state already counts the first differing sample, so
    // the exit fires on the DEBOUNCE_CYCLES-th consecutive one.
    always_ff @(posedge input_clock1_clk_1 or negedge input_input_switch2__clear_2) begin
        if (!input_input_switch2__clear_2) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (sync2) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_WIDTH'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HIGH;
                        level <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync2) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_WIDTH'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync2) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LOW;
                        level <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    level <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.output_led1_d_4    = level;
    assign bus.output_led2_rise_5 = rise;
    assign bus.output_led3_fall_6 = fall;

endmodule
